instr_fetch_ctrl: RTL
=====================

# instr_fetch_ctrl

Fetch sequencer for the 16-bit instruction memory. It owns the program counter and drives the instruction-memory address. It compensates for the memory's one-cycle registered read and presents instructions to decode over a valid/ready handshake. It also handles start, stall, branch redirect, halt and out-of-range fetch faults, and sits between the instruction memory and the decode stage.

## Interface
- `RESET_PC`, default 16'h0000: first fetch address after `start` from IDLE.
- `MEM_DEPTH`, default 128: number of instruction words. Valid addresses are 0..MEM_DEPTH-1. Must be ≤ 65535.
- `HALT_OP`, default 16'hF000: encoding of the halt instruction.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset is asynchronous and active-low.
- `start`  in  1: single-cycle pulse; leaves IDLE or HALT.
- `mem_addr`  out  16: instruction-memory address (combinational). The memory samples it on each rising edge.
- `mem_data`  in  16: memory read data for the address sampled at the previous edge.
- `instr`  out  16: equals `mem_data` (pass-through); meaningful only while `instr_valid`.
- `instr_pc`  out  16: word address of `instr`.
- `instr_valid`  out  1: instruction offered to decode.
- `instr_ready`  in  1: decode accepts. Handshake = `instr_valid` & `instr_ready`.
- `br_taken`  in  1: redirect request from execute.
- `br_target`  in  16: redirect address, qualified by `br_taken`.
- `halted`  out  1: high in HALT.
- `fault`  out  1: high in FAULT.
- `fault_addr`  out  16: offending address.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, HALT, FAULT}.
  - `data_pc`: address whose data is in `mem_data`; drives `instr_pc`.
  - `fetch_pc`: next sequential address.
  - `fault_addr`.
- Reset values:
  - state = IDLE.
  - data_pc = RESET_PC, fetch_pc = RESET_PC+1.
  - fault_addr = 0.
  - instr_valid, halted and fault = 0.
  - mem_addr = RESET_PC.
- All range checks use 17-bit unsigned compare `addr >= MEM_DEPTH`.
- `instr_valid = (state==RUN) & ~br_taken`. A branch kills the current offer combinationally.
- IDLE:
  - mem_addr = RESET_PC.
  - On `start`: data_pc ← RESET_PC, fetch_pc ← RESET_PC+1, go to RUN.
- RUN: priority is branch, then handshake, then hold.
  - **Branch** (`br_taken`), target out of range: go to FAULT; fault_addr ← br_target; mem_addr = data_pc.
  - **Branch**, target in range: mem_addr = br_target; data_pc ← br_target; fetch_pc ← br_target+1. `instr_ready` is ignored this cycle.
  - **Handshake**, `instr==HALT_OP`: go to HALT; mem_addr = data_pc; data_pc is kept.
  - **Handshake**, fetch_pc out of range: go to FAULT; fault_addr ← fetch_pc; mem_addr = data_pc.
  - **Handshake**, otherwise: mem_addr = fetch_pc; data_pc ← fetch_pc; fetch_pc ← fetch_pc+1.
  - **Hold** (valid & ~ready): mem_addr = data_pc. The memory re-reads the same word, so `instr` stays stable. No skip, no duplicate.
- HALT:
  - halted = 1; mem_addr = data_pc+1 when in range, else data_pc.
  - On `start`, data_pc+1 out of range: go to FAULT; fault_addr ← data_pc+1.
  - On `start`, otherwise: data_pc ← data_pc+1, fetch_pc ← data_pc+2, go to RUN.
- FAULT:
  - fault = 1; mem_addr = data_pc.
  - Left only by reset.
- Ignored inputs:
  - `start` in RUN or FAULT.
  - `br_taken` outside RUN.

## Timing
- start → first `instr_valid`: 1 cycle. The memory reads RESET_PC at the start edge.
- Sustained throughput: 1 instruction per cycle with `instr_ready`=1.
- Redirect latency: the target instruction is valid on the cycle after `br_taken`. Exactly 1 bubble.
- Halt: `halted` asserts on the cycle after the HALT_OP handshake. `instr_valid` is 0 from that cycle.
- start from HALT → valid at halt_pc+1 on the following cycle.
- Fault: `fault` and `fault_addr` are set on the cycle after the triggering event. No out-of-range address ever appears on `mem_addr`.
- Async reset mid-operation: outputs take reset values immediately, with no clock needed. The in-flight instruction is lost.

## Test plan
- **Sequential run.** Preload mem[i]=16'h1000+i. Reset, pulse start, hold ready=1.
  - valid rises 1 cycle after start.
  - (instr_pc, instr) = (0, 1000), (1, 1001), (2, 1002) …, one per cycle.
- **Stall.** Drop ready for 3 cycles while offering pc 5.
  - instr holds 16'h1005 and mem_addr=5 throughout.
  - After ready returns, the next accepted instruction is 16'h1006.
- **Branch.** br_taken=1, br_target=16'h0020 while pc 3 is offered with ready=1.
  - instr_valid=0 that cycle.
  - Next cycle: instr_pc=16'h0020, instr=16'h1020. pc 3 is never handshaken.
- **Halt/resume.** mem[7]=16'hF000.
  - Accepting pc 7 makes halted=1 and valid=0 next cycle.
  - Pulse start: next cycle instr_pc=8, instr=16'h1008, halted=0.
- **Faults.**
  - br_target=16'h0080 → fault=1, fault_addr=16'h0080, valid=0, mem_addr stays in range.
  - Separately, run sequentially to pc 127 and accept it → fault_addr=16'h0080.
  - start is ignored after either fault.
- **Async reset mid-run.** Assert rst_n=0 between clock edges.
  - Immediately: valid=0, halted=0, fault=0, mem_addr=RESET_PC, state IDLE.
  - No fetch occurs until the next start.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: instruction-memory port, decode handshake, branch redirect
// and status. The fetch sequencer is the master; memory/decode/execute the slave.
interface instr_fetch_ctrl_if;
    logic        start;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halted;
    logic        fault;
    logic [15:0] fault_addr;

    modport master (
        input  start, mem_data, instr_ready, br_taken, br_target,
        output mem_addr, instr, instr_pc, instr_valid, halted, fault, fault_addr
    );

    modport slave (
        output start, mem_data, instr_ready, br_taken, br_target,
        input  mem_addr, instr, instr_pc, instr_valid, halted, fault, fault_addr
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, hides the memory's one-cycle registered read
// and offers instructions to decode over valid/ready.
module instr_fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned MEM_DEPTH = 128,
    parameter logic [15:0] HALT_OP   = 16'hF000
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_ctrl_if.master  fetchBus
);

    typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} FetchState;

    localparam logic [16:0] DEPTH         = 17'(MEM_DEPTH);
    localparam logic [16:0] RESET_PC_NEXT = {1'b0, RESET_PC} + 17'd1;

    FetchState   state_q, state_d;
    logic [15:0] dataPc_q, dataPc_d;
    logic [16:0] fetchPc_q, fetchPc_d;
    logic [15:0] faultAddr_q, faultAddr_d;
    logic [15:0] memAddr;
    logic [16:0] haltNext;
    logic [16:0] brNext;
    logic        offerValid;
    logic        handshake;

    // 17-bit compare so that address+1 overflow past 16'hFFFF still counts as out of range.
    function automatic logic outOfRange(input logic [16:0] addr);
        return addr >= DEPTH;
    endfunction

    assign haltNext   = {1'b0, dataPc_q} + 17'd1;
    assign brNext     = {1'b0, fetchBus.br_target} + 17'd1;
    assign offerValid = (state_q == RUN) && !fetchBus.br_taken;
    assign handshake  = offerValid && fetchBus.instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dataPc_q    <= RESET_PC;
            fetchPc_q   <= RESET_PC_NEXT;
            faultAddr_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            dataPc_q    <= dataPc_d;
            fetchPc_q   <= fetchPc_d;
            faultAddr_q <= faultAddr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dataPc_d    = dataPc_q;
        fetchPc_d   = fetchPc_q;
        faultAddr_d = faultAddr_q;
        memAddr     = dataPc_q;

        case (state_q)
            IDLE: begin
                memAddr = RESET_PC;
                if (fetchBus.start) begin
                    dataPc_d  = RESET_PC;
                    fetchPc_d = RESET_PC_NEXT;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Re-presenting dataPc on a stall makes the memory re-read the same word.
                if (fetchBus.br_taken) begin
                    if (outOfRange({1'b0, fetchBus.br_target})) begin
                        state_d     = FAULT;
                        faultAddr_d = fetchBus.br_target;
                    end else begin
                        memAddr   = fetchBus.br_target;
                        dataPc_d  = fetchBus.br_target;
                        fetchPc_d = brNext;
                    end
                end else if (handshake) begin
                    if (fetchBus.mem_data == HALT_OP) begin
                        state_d = HALT;
                    end else if (outOfRange(fetchPc_q)) begin
                        state_d     = FAULT;
                        faultAddr_d = fetchPc_q[15:0];
                    end else begin
                        memAddr   = fetchPc_q[15:0];
                        dataPc_d  = fetchPc_q[15:0];
                        fetchPc_d = fetchPc_q + 17'd1;
                    end
                end
            end
            HALT: begin
                if (!outOfRange(haltNext)) begin
                    memAddr = haltNext[15:0];
                end
                if (fetchBus.start) begin
                    if (outOfRange(haltNext)) begin
                        state_d     = FAULT;
                        faultAddr_d = haltNext[15:0];
                    end else begin
                        dataPc_d  = haltNext[15:0];
                        fetchPc_d = {1'b0, dataPc_q} + 17'd2;
                        state_d   = RUN;
                    end
                end
            end
            FAULT: begin
                memAddr = dataPc_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetchBus.mem_addr    = memAddr;
    assign fetchBus.instr       = fetchBus.mem_data;
    assign fetchBus.instr_pc    = dataPc_q;
    assign fetchBus.instr_valid = offerValid;
    assign fetchBus.halted      = (state_q == HALT);
    assign fetchBus.fault       = (state_q == FAULT);
    assign fetchBus.fault_addr  = faultAddr_q;

endmodule
